nboy_rom_loader: RTL and testbench
==================================

# nboy_rom_loader

Sits between the HPS download port and the Naughty Boy core's ROM stores. Receives the byte stream of ROM index 0 and decodes each linear address into program, two graphics, or colour-PROM regions. Buffers one byte and throttles the source while a target is busy, and checks length and ordering. Holds the core in reset until a complete, valid image has been written.

## Interface
Parameters:
- PROG_END, 16'h4000: first address past the program ROM (16 KB Z80 code).
- GFX1_END, 16'h6000: first address past graphics bank 1 (8 KB).
- GFX2_END, 16'h8000: first address past graphics bank 2 (8 KB).
- PROM_END, 16'h8200: first address past the colour PROMs (512 B); also the required image length.

Ports:
- clk_sys  in  1  system clock, 11 MHz domain of the core.
- reset_n  in  1  asynchronous, active-low reset.
- dn_download  in  1  level, high while ROM index 0 transfer is active.
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  16  byte address.
- dn_data  in  8  byte data.
- dn_wait  out  1  source must not issue dn_wr while high.
- tgt_busy  in  1  target stores cannot accept a write this cycle.
- tgt_addr  out  15  region-local address (registered).
- tgt_data  out  8  byte (registered).
- wr_prog, wr_gfx1, wr_gfx2, wr_prom  out  1 each  one-hot write strobes.
- core_reset  out  1  high unless the state is DONE.
- rom_ok  out  1  image complete and valid.
- load_err  out  1  length, order or protocol error on last load.
- checksum  out  8  modulo-256 sum of accepted bytes.

## Operation
- States: IDLE, LOAD, DRAIN, DONE, ERROR.
- IDLE → LOAD on dn_download rising edge. Entry clears the byte counter, checksum, rom_ok, load_err, err_flag and buffer.
- LOAD: a dn_wr with buffer empty captures addr/data into the 1-entry buffer, increments the counter, and adds the data to the checksum.
- Ordering: if dn_addr ≠ counter value, the byte is still captured and written, and err_flag is set.
- Out of range: if dn_addr ≥ PROM_END, the byte is captured but no strobe fires, and err_flag is set.
- Protocol violation: a dn_wr while the buffer is full drops the byte and sets err_flag.
- Region decode, on the buffered address a:
  - a < PROG_END → prog, local = a.
  - a < GFX1_END → gfx1, local = a − PROG_END.
  - a < GFX2_END → gfx2, local = a − GFX1_END.
  - a < PROM_END → prom, local = a − GFX2_END.
  - Subtraction is 16-bit; the result is truncated to 15 bits.
- Drain: the selected strobe = buf_valid & !tgt_busy & region match. buf_valid clears in that same cycle.
- dn_download falling edge (LOAD) → DRAIN. DRAIN waits for buffer empty, then:
  - → DONE if counter == PROM_END and err_flag == 0;
  - otherwise → ERROR.
- DONE: rom_ok = 1, core_reset = 0.
- ERROR: load_err = 1, core_reset = 1.
- From DONE or ERROR, a dn_download rising edge → LOAD (reload).
- dn_download rising edge while in DRAIN: that edge is ignored until DRAIN completes.

## Timing
- Reset values: state IDLE, dn_wait 0, all wr_* 0, tgt_addr 0, tgt_data 0, core_reset 1, rom_ok 0, load_err 0, checksum 0.
- dn_download edge detect uses a 1-cycle registered delay; state changes 1 cycle after the input edge.
- Capture: dn_wr in cycle N → buf_valid, tgt_addr, tgt_data and dn_wait = 1 in cycle N+1.
- Strobe: earliest in cycle N+1 if tgt_busy is 0. dn_wait falls in cycle N+2.
- Back-to-back throughput with tgt_busy low: one byte per 2 cycles.
- tgt_busy held high for k cycles delays the strobe by k cycles. tgt_addr and tgt_data stay stable meanwhile.
- Counter is 17 bits so that PROM_END+overrun is detected without wrap.
- Checksum wraps mod 256.
- reset_n asserted mid-load: everything returns to reset values immediately, and no strobe is issued for the buffered byte.

## Structure
- Shared package nboy_pkg: region boundary constants (PROG_END…PROM_END), state enum typedef, and region enum {REG_PROG, REG_GFX1, REG_GFX2, REG_PROM, REG_NONE}.
- Sub-module nboy_region_decode (combinational: address → region enum + local address), reused by the hiscore RAM mapper.
- FSM, counter, checksum and buffer live in the top module.

## Test plan
- Full image, 0x8200 sequential bytes, tgt_busy = 0, data = addr[7:0] → exactly 0x4000 wr_prog, 0x2000 wr_gfx1, 0x2000 wr_gfx2 and 0x200 wr_prom strobes. rom_ok = 1, core_reset = 0, checksum = 0x00 (as computed by the reference model).
- Byte at 0x6005 → wr_gfx2 with tgt_addr = 0x0005. Byte at 0x8000 → wr_prom with tgt_addr = 0x000.
- tgt_busy high for 5 cycles after capture → dn_wait stays 1 for 6 cycles and the strobe fires once, in the first non-busy cycle, with unchanged addr/data.
- Short image (0x8100 bytes) or one skipped address (0x1233 → 0x1235) → ERROR, load_err = 1, core_reset = 1.
- Byte at 0x8200 → no strobe, load_err after download ends. dn_wr issued while dn_wait = 1 → byte dropped, load_err = 1.
- reset_n pulsed low at byte 0x3000 → all outputs return to reset values at once. A subsequent complete download reaches DONE.

Source files
------------

// File: rtl/nboy_pkg.sv
// Shared definitions for the Naughty Boy ROM loader and related address mappers:
// region boundaries, loader state encoding and region encoding.
package nboy_pkg;

  localparam logic [15:0] PROG_END = 16'h4000;
  localparam logic [15:0] GFX1_END = 16'h6000;
  localparam logic [15:0] GFX2_END = 16'h8000;
  localparam logic [15:0] PROM_END = 16'h8200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    REG_PROG,
    REG_GFX1,
    REG_GFX2,
    REG_PROM,
    REG_NONE
  } region_e;

endpackage

// File: rtl/nboy_region_decode.sv
// Combinational map from a linear ROM image address to its target region
// and the region-local address.
module nboy_region_decode #(
  parameter logic [15:0] PROG_END = nboy_pkg::PROG_END,
  parameter logic [15:0] GFX1_END = nboy_pkg::GFX1_END,
  parameter logic [15:0] GFX2_END = nboy_pkg::GFX2_END,
  parameter logic [15:0] PROM_END = nboy_pkg::PROM_END
) (
  input  logic [15:0]      addr,
  output nboy_pkg::region_e region,
  output logic [14:0]      local_addr
);
  import nboy_pkg::*;

  // Offsets are formed at 16 bits and truncated to the 15-bit local bus.
  always_comb begin
    region     = REG_NONE;
    local_addr = 15'(addr - PROM_END);
    if (addr < PROG_END) begin
      region     = REG_PROG;
      local_addr = addr[14:0];
    end else if (addr < GFX1_END) begin
      region     = REG_GFX1;
      local_addr = 15'(addr - PROG_END);
    end else if (addr < GFX2_END) begin
      region     = REG_GFX2;
      local_addr = 15'(addr - GFX1_END);
    end else if (addr < PROM_END) begin
      region     = REG_PROM;
      local_addr = 15'(addr - GFX2_END);
    end
  end

endmodule

// File: rtl/nboy_rom_loader.sv
// Routes the HPS ROM download stream into the core's ROM stores through a
// one-byte buffer, validates the image and holds the core in reset until done.
module nboy_rom_loader #(
  parameter logic [15:0] PROG_END = nboy_pkg::PROG_END,
  parameter logic [15:0] GFX1_END = nboy_pkg::GFX1_END,
  parameter logic [15:0] GFX2_END = nboy_pkg::GFX2_END,
  parameter logic [15:0] PROM_END = nboy_pkg::PROM_END
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        dn_wait,
  input  logic        tgt_busy,
  output logic [14:0] tgt_addr,
  output logic [7:0]  tgt_data,
  output logic        wr_prog,
  output logic        wr_gfx1,
  output logic        wr_gfx2,
  output logic        wr_prom,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        load_err,
  output logic [7:0]  checksum
);
  import nboy_pkg::*;

  state_e      state_q, state_d;
  region_e     region_q, region_d, dec_region;
  logic [14:0] dec_local;
  logic        dl_q;
  logic        buf_valid_q, buf_valid_d;
  logic [14:0] tgt_addr_q, tgt_addr_d;
  logic [7:0]  tgt_data_q, tgt_data_d;
  logic [16:0] count_q, count_d;
  logic [7:0]  checksum_q, checksum_d;
  logic        err_q, err_d;
  logic        rom_ok_q, rom_ok_d;
  logic        load_err_q, load_err_d;
  logic        core_reset_q, core_reset_d;
  logic        dl_rise, dl_fall, drain;

  nboy_region_decode #(
    .PROG_END(PROG_END),
    .GFX1_END(GFX1_END),
    .GFX2_END(GFX2_END),
    .PROM_END(PROM_END)
  ) u_decode (
    .addr      (dn_addr),
    .region    (dec_region),
    .local_addr(dec_local)
  );

  assign dl_rise = dn_download & ~dl_q;
  assign dl_fall = ~dn_download & dl_q;
  assign drain   = buf_valid_q & ~tgt_busy;

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    buf_valid_d = buf_valid_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_data_d  = tgt_data_q;
    count_d     = count_q;
    checksum_d  = checksum_q;
    err_d       = err_q;
    if (drain) buf_valid_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (dl_rise) begin
          state_d     = S_LOAD;
          count_d     = '0;
          checksum_d  = '0;
          err_d       = 1'b0;
          buf_valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (dn_wr) begin
          if (buf_valid_q) begin
            // Source ignored dn_wait: the byte is lost, so the image is bad.
            err_d = 1'b1;
          end else begin
            buf_valid_d = 1'b1;
            region_d    = dec_region;
            tgt_addr_d  = dec_local;
            tgt_data_d  = dn_data;
            count_d     = count_q + 17'd1;
            checksum_d  = checksum_q + dn_data;
            if ({1'b0, dn_addr} != count_q || dec_region == REG_NONE) err_d = 1'b1;
          end
        end
        if (dl_fall) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!buf_valid_q) begin
          state_d = (count_q == {1'b0, PROM_END} && !err_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rom_ok_d     = (state_d == S_DONE);
    load_err_d   = (state_d == S_ERROR);
    core_reset_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      region_q     <= REG_NONE;
      dl_q         <= 1'b0;
      buf_valid_q  <= 1'b0;
      tgt_addr_q   <= '0;
      tgt_data_q   <= '0;
      count_q      <= '0;
      checksum_q   <= '0;
      err_q        <= 1'b0;
      rom_ok_q     <= 1'b0;
      load_err_q   <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      dl_q         <= dn_download;
      buf_valid_q  <= buf_valid_d;
      tgt_addr_q   <= tgt_addr_d;
      tgt_data_q   <= tgt_data_d;
      count_q      <= count_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
      rom_ok_q     <= rom_ok_d;
      load_err_q   <= load_err_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Strobes follow tgt_busy within the cycle so a free target takes the byte at once.
  assign wr_prog    = drain && (region_q == REG_PROG);
  assign wr_gfx1    = drain && (region_q == REG_GFX1);
  assign wr_gfx2    = drain && (region_q == REG_GFX2);
  assign wr_prom    = drain && (region_q == REG_PROM);
  assign dn_wait    = buf_valid_q;
  assign tgt_addr   = tgt_addr_q;
  assign tgt_data   = tgt_data_q;
  assign checksum   = checksum_q;
  assign rom_ok     = rom_ok_q;
  assign load_err   = load_err_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_nboy_rom_loader.sv
// Scoreboard bench for nboy_rom_loader: stimulus queues expected target writes,
// a monitor pops and compares them whenever a write strobe fires.
module tb_nboy_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        tgt_busy = 1'b0;
  logic        dn_wait;
  logic [14:0] tgt_addr;
  logic [7:0]  tgt_data;
  logic        wr_prog, wr_gfx1, wr_gfx2, wr_prom;
  logic        core_reset, rom_ok, load_err;
  logic [7:0]  checksum;

  nboy_rom_loader dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dn_download(dn_download),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .dn_wait    (dn_wait),
    .tgt_busy   (tgt_busy),
    .tgt_addr   (tgt_addr),
    .tgt_data   (tgt_data),
    .wr_prog    (wr_prog),
    .wr_gfx1    (wr_gfx1),
    .wr_gfx2    (wr_gfx2),
    .wr_prom    (wr_prom),
    .core_reset (core_reset),
    .rom_ok     (rom_ok),
    .load_err   (load_err),
    .checksum   (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]  rg;
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  quiet = 1'b0;
  int  n_strobe = 0;
  int  n_reg[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Reference map: region index 0..3 = prog, gfx1, gfx2, prom; returns 0 when out of range.
  function automatic bit model(input logic [15:0] a, input logic [7:0] d, output wr_t w);
    logic [15:0] base;
    w.data = d;
    if (a < 16'h4000) begin w.rg = 2'd0; base = 16'h0000; end
    else if (a < 16'h6000) begin w.rg = 2'd1; base = 16'h4000; end
    else if (a < 16'h8000) begin w.rg = 2'd2; base = 16'h6000; end
    else begin w.rg = 2'd3; base = 16'h8000; end
    w.addr = 15'(a - base);
    return a < 16'h8200;
  endfunction

  always @(negedge clk_sys) begin : monitor
    logic [3:0] s;
    wr_t        e;
    int         idx;
    if (reset_n) begin
      s = {wr_prom, wr_gfx2, wr_gfx1, wr_prog};
      if (s != 4'b0) begin
        n_strobe++;
        idx = s[1] ? 1 : s[2] ? 2 : s[3] ? 3 : 0;
        n_reg[idx]++;
        chk("strobe_onehot", $countones(s), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got region %0d addr %h data %h, required no write",
                   idx, tgt_addr, tgt_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_region", idx, e.rg);
          chk("wr_addr", tgt_addr, e.addr);
          chk("wr_data", tgt_data, e.data);
          if (!quiet) $display("%0t write region=%0d addr=%h data=%h", $time, idx, tgt_addr, tgt_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl();
    dn_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit push);
    wr_t w;
    int  n;
    n = 0;
    while (dn_wait && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: dn_wait still %0b, required 0 within 100 cycles", dn_wait);
    end
    if (push && model(a, d, w)) exp_q.push_back(w);
    dn_wr = 1'b1;
    dn_addr = a;
    dn_data = d;
    tick();
    dn_wr = 1'b0;
  endtask

  task automatic end_dl(input string name, input bit exp_ok);
    int n;
    dn_download = 1'b0;
    n = 0;
    while (!(rom_ok || load_err) && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_rom_ok"}, rom_ok, exp_ok);
    chk({name, "_load_err"}, load_err, !exp_ok);
    chk({name, "_core_reset"}, core_reset, !exp_ok);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_dn_wait"}, dn_wait, 0);
    chk({name, "_strobes"}, {wr_prom, wr_gfx2, wr_gfx1, wr_prog}, 0);
    chk({name, "_tgt_addr"}, tgt_addr, 0);
    chk({name, "_tgt_data"}, tgt_data, 0);
    chk({name, "_core_reset"}, core_reset, 1);
    chk({name, "_rom_ok"}, rom_ok, 0);
    chk({name, "_load_err"}, load_err, 0);
    chk({name, "_checksum"}, checksum, 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Isolated region decodes; image is out of order so the load must fail.
    start_dl();
    send_byte(16'h6005, 8'hA5, 1'b1);
    send_byte(16'h8000, 8'h3C, 1'b1);
    tick();
    chk("decode_checksum", checksum, 8'hE1);
    end_dl("decode", 1'b0);

    // Target busy for 5 cycles after capture, then a short but ordered image.
    start_dl();
    tgt_busy = 1'b1;
    base = n_strobe;
    exp_q.push_back('{rg: 2'd0, addr: 15'h0000, data: 8'h5A});
    dn_wr = 1'b1;
    dn_addr = 16'h0000;
    dn_data = 8'h5A;
    tick();
    dn_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) tgt_busy = 1'b0;
      @(negedge clk_sys);
      #1;
      chk("busy_dn_wait", dn_wait, 1);
      chk("busy_tgt_addr", tgt_addr, 15'h0000);
      chk("busy_tgt_data", tgt_data, 8'h5A);
      chk("busy_strobe_count", n_strobe - base, (i == 5) ? 1 : 0);
      tick();
    end
    chk("busy_release", dn_wait, 0);
    for (int a = 1; a < 4; a++) send_byte(16'(a), 8'(a + 16), 1'b1);
    end_dl("short", 1'b0);

    // Skipped address inside an otherwise sequential stream.
    start_dl();
    for (int a = 0; a < 4; a++) send_byte(16'(a), 8'(a), 1'b1);
    send_byte(16'h0005, 8'h05, 1'b1);
    end_dl("skip", 1'b0);

    // Out-of-range byte: captured and counted in the checksum, but never written.
    start_dl();
    send_byte(16'h8200, 8'h11, 1'b1);
    chk("oor_captured", dn_wait, 1);
    tick();
    chk("oor_checksum", checksum, 8'h11);
    end_dl("oor", 1'b0);

    // Protocol violation: second dn_wr while dn_wait is high is dropped.
    start_dl();
    send_byte(16'h0000, 8'h42, 1'b1);
    chk("proto_wait_high", dn_wait, 1);
    dn_wr = 1'b1;
    dn_addr = 16'h0001;
    dn_data = 8'h77;
    tick();
    dn_wr = 1'b0;
    tick();
    chk("proto_checksum", checksum, 8'h42);
    end_dl("proto", 1'b0);

    // Asynchronous reset with a byte parked in the buffer.
    start_dl();
    send_byte(16'h0000, 8'h01, 1'b1);
    tick();
    tgt_busy = 1'b1;
    send_byte(16'h3000, 8'h99, 1'b0);
    chk("prereset_wait", dn_wait, 1);
    chk("prereset_checksum", checksum, 8'h9A);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midload_reset");
    tgt_busy = 1'b0;
    dn_download = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Complete image after the reset.
    quiet = 1'b1;
    n_reg = '{0, 0, 0, 0};
    start_dl();
    for (int a = 0; a < 'h8200; a++) send_byte(16'(a), 8'(a), 1'b1);
    end_dl("full", 1'b1);
    chk("full_prog_writes", n_reg[0], 32'h4000);
    chk("full_gfx1_writes", n_reg[1], 32'h2000);
    chk("full_gfx2_writes", n_reg[2], 32'h2000);
    chk("full_prom_writes", n_reg[3], 32'h0200);
    chk("full_checksum", checksum, 8'h00);
    $display("full image: prog=%0d gfx1=%0d gfx2=%0d prom=%0d checksum=%h",
             n_reg[0], n_reg[1], n_reg[2], n_reg[3], checksum);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
